// File: rtl/valid_stream_fifo_pkg.sv
// Shared constants for the valid-stream-to-ready FIFO: drop counter width and its saturation ceiling.
package valid_stream_fifo_pkg;

  localparam int DROP_COUNT_WIDTH = 16;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/valid_stream_to_ready_fifo_wrap_ptr.sv
// Modulo-depth pointer that steps by one on inc and wraps from depth-1 back to 0.
module wrap_ptr #(
  parameter int depth = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   inc,
  output logic [((depth > 1) ? $clog2(depth) : 1)-1:0] ptr
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;

  // Explicit wrap compare keeps non-power-of-two depths inside the storage range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(depth - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/valid_stream_to_ready_fifo.sv
// First-word fall-through FIFO bridging an unstallable valid-only stream to a ready/valid sink.
// Entries arriving while full are dropped and tallied; define VALID_STREAM_FIFO_DEBUG_EN for slot visibility ports.
module valid_stream_to_ready_fifo
  import valid_stream_fifo_pkg::*;
#(
  parameter int width = 256,
  parameter int depth = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [width-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [width-1:0]              out_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(depth+1)-1:0]    count,
  input  logic                          clr_overflow,
  output logic                          overflow,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count
`ifdef VALID_STREAM_FIFO_DEBUG_EN
  ,
  output logic                          debug_valid [depth],
  output logic [width-1:0]              debug_data  [depth]
`endif
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(depth));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  wrap_ptr #(.depth(depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  wrap_ptr #(.depth(depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage is deliberately unreset; writes are held off while rst is high.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop coinciding with a clear wins: the new drop is the first one counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= drop;
      drop_count <= drop ? DROP_COUNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_COUNT_MAX) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

`ifdef VALID_STREAM_FIFO_DEBUG_EN
  // A physical slot is live when its distance ahead of rd_ptr is below count.
  always_comb begin
    for (int i = 0; i < depth; i++) begin
      debug_data[i]  = mem[i];
      debug_valid[i] = (((i - int'(rd_ptr) + depth) % depth) < int'(count));
    end
  end
`endif

endmodule

// File: tb/tb_valid_stream_to_ready_fifo.sv
// Directed self-checking bench for valid_stream_to_ready_fifo at width=8, depth=4.
module tb_valid_stream_to_ready_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             clr_overflow;
  logic             overflow;
  logic [15:0]      drop_count;

  int checks = 0;
  int errors = 0;

  valid_stream_to_ready_fifo #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .clr_overflow (clr_overflow),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic rdy, input logic clr);
    in_valid     = v;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Three pushes, no bypass while empty
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    #1;
    checkOutput("no_bypass_out_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("first_push_out_valid", 32'(out_valid), 32'd1);
    checkOutput("first_push_out_data", 32'(out_data), 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("three_push_count", 32'(count), 32'd3);
    checkOutput("three_push_head", 32'(out_data), 32'h11);

    // Fill then drop
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    step();
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    step();
    checkOutput("drop_full", 32'(full), 32'd1);
    checkOutput("drop_overflow", 32'(overflow), 32'd1);
    checkOutput("drop_drop_count", 32'(drop_count), 32'd1);
    checkOutput("drop_head", 32'(out_data), 32'h11);
    checkOutput("drop_count_unchanged", 32'(count), 32'd4);

    // Full with simultaneous pop accepts BB
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
    step();
    checkOutput("fullpop_count", 32'(count), 32'd4);
    checkOutput("fullpop_no_drop", 32'(drop_count), 32'd1);
    checkOutput("fullpop_head", 32'(out_data), 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("drain_head_33", 32'(out_data), 32'h33);
    step();
    checkOutput("drain_head_44", 32'(out_data), 32'h44);
    step();
    checkOutput("drain_head_bb", 32'(out_data), 32'hBB);
    checkOutput("drain_count_1", 32'(count), 32'd1);
    step();
    checkOutput("drain_empty", 32'(empty), 32'd1);
    step();
    checkOutput("empty_pop_ignored", 32'(count), 32'd0);

    // Streaming push+pop across two pointer wraps
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, WIDTH'(8'h50 + i), 1'b1, 1'b0);
      if (i > 0) begin
        checkOutput($sformatf("stream_head_%0d", i), 32'(out_data), 32'h50 + 32'(i - 1));
        checkOutput($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
      end
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_last_head", 32'(out_data), 32'h59);
    checkOutput("stream_last_count", 32'(count), 32'd1);
    step();
    checkOutput("stream_drained", 32'(empty), 32'd1);

    // Drop coinciding with clear, then a plain clear
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 8'h64, 1'b0, 1'b0);
    step();
    checkOutput("second_drop_count", 32'(drop_count), 32'd2);
    applyStimulus(1'b1, 8'h65, 1'b0, 1'b1);
    step();
    checkOutput("clr_drop_overflow", 32'(overflow), 32'd1);
    checkOutput("clr_drop_drop_count", 32'(drop_count), 32'd1);
    checkOutput("clr_drop_head", 32'(out_data), 32'h60);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    checkOutput("clr_drop_count", 32'(drop_count), 32'd0);

    // Asynchronous reset with three stored entries
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 8'h70, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    checkOutput("pre_rst_head", 32'(out_data), 32'h61);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("rst_in_valid_count", 32'(count), 32'd0);
    checkOutput("rst_in_valid_drops", 32'(drop_count), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("post_rst_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_rst_push_head", 32'(out_data), 32'h77);
    checkOutput("post_rst_push_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/valid_stream_to_ready_fifo.md
VALID_STREAM_TO_READY_FIFO -- requirements
Module: valid_stream_to_ready_fifo

Interface
REQ-001 Parameter width, default 256: data bits per entry.
REQ-002 Parameter depth, default 8: number of storage entries; any value >= 2, not required to be a power of two.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream valid-only stream qualifier; upstream has no ready and cannot be stalled.
REQ-006 in_data  input  width  upstream payload.
REQ-007 out_valid  output  1  FIFO holds at least one entry.
REQ-008 out_ready  input  1  downstream accepts the head entry.
REQ-009 out_data  output  width  head entry payload.
REQ-010 full  output  1  count == depth.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  $clog2(depth+1)  number of stored entries.
REQ-013 clr_overflow  input  1  synchronous clear of overflow and drop_count.
REQ-014 overflow  output  1  sticky: one or more entries dropped since the last clear or reset.
REQ-015 drop_count  output  16  number of dropped entries, saturating.

Function
REQ-016 Pop occurs when out_valid && out_ready; pop with out_valid low is ignored.
REQ-017 Push occurs when in_valid && (!full || pop) in the same cycle; a full FIFO with a simultaneous pop accepts the new entry and count stays depth.
REQ-018 Drop occurs when in_valid && full && !pop; the entry is discarded and storage, pointers and count are unchanged.
REQ-019 out_data is a combinational read of the entry at rd_ptr (first-word fall-through); out_data is don't-care when out_valid is low.
REQ-020 An entry pushed in cycle N is visible on out_valid/out_data in cycle N+1; there is no same-cycle bypass from in_data to out_data, including when the FIFO is empty.
REQ-021 wr_ptr and rd_ptr each advance by 1 on push or pop respectively and wrap from depth-1 to 0.
REQ-022 count increments on push-only, decrements on pop-only, and holds on simultaneous push and pop or when neither occurs.
REQ-023 A drop sets overflow and increments drop_count, which saturates at 16'hFFFF.
REQ-024 clr_overflow clears overflow and sets drop_count to 0, except when a drop occurs in the same cycle: overflow is then 1 and drop_count is 1.
REQ-025 Stored entries are never overwritten before they are popped.

Reset
REQ-026 Asserting rst immediately sets rd_ptr, wr_ptr, count, overflow and drop_count to 0; empty then reads 1 and out_valid and full read 0.
REQ-027 Storage contents are not reset.
REQ-028 Reset asserted mid-operation discards all stored entries; an in_valid present while rst is high is neither stored nor counted as a drop.

Configuration
REQ-029 Macro VALID_STREAM_FIFO_DEBUG_EN, when defined, adds output debug_valid [depth] and output debug_data [depth][width], both combinational.
REQ-030 With VALID_STREAM_FIFO_DEBUG_EN defined, debug_valid[i] is 1 exactly when slot i holds an unpopped entry (slot index is physical), and debug_data[i] equals storage slot i.
REQ-031 With VALID_STREAM_FIFO_DEBUG_EN undefined, both debug ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-032 The package valid_stream_fifo_pkg holds the constant DROP_COUNT_WIDTH = 16 and the saturation maximum.
REQ-033 Sub-module wrap_ptr (parameter depth; inputs clk, rst, inc; output ptr) implements the wrapping pointer and is instantiated twice, for rd_ptr and wr_ptr.

Verification (width=8, depth=4)
REQ-034 Bench scenario: push 8'h11,8'h22,8'h33 on consecutive cycles with out_ready=0 -> count=3, out_data=8'h11 one cycle after the first push.
REQ-035 Bench scenario: fill to 4 entries, then push 8'hAA with out_ready=0 -> full=1, overflow=1, drop_count=1, head unchanged.
REQ-036 Bench scenario: full FIFO, push 8'hBB with out_ready=1 -> count stays 4, no drop, 8'hBB emerges fourth after later pops.
REQ-037 Bench scenario: 10 pushes interleaved with pops so the pointers wrap twice -> output order equals input order and no entry is lost.
REQ-038 Bench scenario: drop and clr_overflow in the same cycle -> overflow=1, drop_count=1; clr_overflow alone next cycle -> overflow=0, drop_count=0.
REQ-039 Bench scenario: assert rst with 3 entries stored -> count=0, empty=1, out_valid=0 immediately, without waiting for a clock edge.
